cordic_sweep_ctrl: RTL

Sequencer that drives the frequency word of the CORDIC angle/sine generator through a programmable linear sweep (chirp/step scan). It latches start, stop, step and dwell on a start pulse, then steps the frequency up or down, holding each value for a dwell period. It saturates exactly at the stop value and signals completion. It sits between the control/register interface and the `freq` input of the angle-generator/CORDIC pair.

---
 rtl/cordic_sweep_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_sweep_ctrl.sv
// cordic_sweep_ctrl: linear frequency-sweep sequencer for the CORDIC angle
// generator. It latches start/stop/step/dwell on a start pulse, then walks
// freq_out from f_start towards f_stop, holding each point dwell+1 cycles.
// The final point is clamped to f_stop exactly, so freq_out never wraps.
//
// Optional build feature: define SWEEP_LOOP_EN to add the `loop` input, which
// restarts the sweep from the latched f_start after each completed pass.
//
// Handshake: start and abort are single-cycle requests with no ready output.
// start is accepted only at an edge where the FSM is in IDLE and abort is low;
// a start seen at any other edge is dropped, never queued. abort is always
// accepted and wins over start.
module cordic_sweep_ctrl #(
  parameter int FREQ_WIDTH  = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
`ifdef SWEEP_LOOP_EN
  input  logic                   loop,
`endif
  input  logic [FREQ_WIDTH-1:0]  f_start,
  input  logic [FREQ_WIDTH-1:0]  f_stop,
  input  logic [FREQ_WIDTH-1:0]  f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [FREQ_WIDTH-1:0]  freq_out,
  output logic                   freq_valid,
  output logic                   step_tick,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_n;

  // Configuration captured at the accepted start edge.
  logic [FREQ_WIDTH-1:0]  start_l;
  logic [FREQ_WIDTH-1:0]  stop_l;
  logic [FREQ_WIDTH-1:0]  step_l;
  logic [DWELL_WIDTH-1:0] dwell_l;
  logic                   dir_up_l;

  logic [DWELL_WIDTH-1:0] cnt;
  logic [DWELL_WIDTH-1:0] cnt_n;
  logic [FREQ_WIDTH-1:0]  freq_n;
  logic                   busy_n;
  logic                   valid_n;
  logic                   tick_n;
  logic                   done_n;
  logic                   cfg_load;

  // One extra bit on both candidates so carry (up) and borrow (down) are
  // visible; that bit is what keeps freq_out from wrapping past f_stop.
  logic [FREQ_WIDTH:0]    sum_w;
  logic [FREQ_WIDTH:0]    diff_w;
  logic                   hit_stop;
  logic                   point_end;
  logic                   single_in;
  logic                   single_l;
  logic                   loop_req;

`ifdef SWEEP_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  assign sum_w     = {1'b0, freq_out} + {1'b0, step_l};
  assign diff_w    = {1'b0, freq_out} - {1'b0, step_l};
  assign hit_stop  = dir_up_l ? (sum_w >= {1'b0, stop_l})
                              : (diff_w[FREQ_WIDTH] || (diff_w[FREQ_WIDTH-1:0] <= stop_l));
  assign point_end = (cnt == dwell_l);

  // A sweep that cannot move (no step, or already at the stop value) is a
  // single point and goes straight to LAST.
  assign single_in = (f_start == f_stop) || (f_step == '0);
  assign single_l  = (start_l == stop_l) || (step_l == '0);

  assign state_dbg = state;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and next-datapath decode; abort overrides every state.
  always_comb begin
    state_n  = state;
    freq_n   = freq_out;
    busy_n   = busy;
    valid_n  = freq_valid;
    tick_n   = 1'b0;
    done_n   = 1'b0;
    cfg_load = 1'b0;
    cnt_n    = cnt + 1'b1;
    if (abort) begin
      state_n = S_IDLE;
      freq_n  = '0;
      busy_n  = 1'b0;
      valid_n = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_n = '0;
          if (start) begin
            cfg_load = 1'b1;
            freq_n   = f_start;
            busy_n   = 1'b1;
            valid_n  = 1'b1;
            tick_n   = 1'b1;
            state_n  = single_in ? S_LAST : S_RUN;
          end
        end
        S_RUN: begin
          if (point_end) begin
            cnt_n  = '0;
            tick_n = 1'b1;
            if (hit_stop) begin
              freq_n  = stop_l;
              state_n = S_LAST;
            end else begin
              freq_n = dir_up_l ? sum_w[FREQ_WIDTH-1:0] : diff_w[FREQ_WIDTH-1:0];
            end
          end
        end
        S_LAST: begin
          if (point_end) begin
            cnt_n  = '0;
            done_n = 1'b1;
            if (loop_req) begin
              freq_n  = start_l;
              tick_n  = 1'b1;
              state_n = single_l ? S_LAST : S_RUN;
            end else begin
              state_n = S_IDLE;
              busy_n  = 1'b0;
              valid_n = 1'b0;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          freq_n  = '0;
          busy_n  = 1'b0;
          valid_n = 1'b0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Output and dwell-counter registers; freq_out holds after normal completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      freq_out   <= '0;
      freq_valid <= 1'b0;
      step_tick  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
    end else begin
      freq_out   <= freq_n;
      freq_valid <= valid_n;
      step_tick  <= tick_n;
      busy       <= busy_n;
      done       <= done_n;
      cnt        <= cnt_n;
    end
  end

  // Configuration capture; untouched for the rest of the sweep.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_l  <= '0;
      stop_l   <= '0;
      step_l   <= '0;
      dwell_l  <= '0;
      dir_up_l <= 1'b1;
    end else if (cfg_load) begin
      start_l  <= f_start;
      stop_l   <= f_stop;
      step_l   <= f_step;
      dwell_l  <= dwell;
      dir_up_l <= (f_start <= f_stop);
    end
  end

endmodule
